// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared state encodings and pipeline register indices
// Contents:
//   state_t   hazard FSM state: RUN (no multi-cycle op), EX_BUSY (multi-cycle op occupying EX)
//   REG_*     indices of the PC and the four pipeline registers in the internal enable/flush vectors
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        EX_BUSY = 1'b1
    } state_t;

    localparam int NUM_REGS   = 5;
    localparam int REG_PC     = 0;
    localparam int REG_IF_ID  = 1;
    localparam int REG_ID_EX  = 2;
    localparam int REG_EX_MEM = 3;
    localparam int REG_MEM_WB = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// rtl/pipeline_hazard_ctrl_load_use_detect.sv - load-use hazard comparator
// Ports:
//   id_rs1, id_rs2             in   source registers of the instruction in ID
//   id_uses_rs1, id_uses_rs2   in   ID instruction actually reads rs1 / rs2
//   ex_rd                      in   destination register of the instruction in EX
//   ex_mem_read                in   EX instruction is a load
//   hazard                     out  ID needs a value the EX load has not produced yet
module load_use_detect #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    output logic                      hazard
);

    logic rd_live;
    logic rs1_match;
    logic rs2_match;

    // x0 is hardwired to zero, so a load targeting it never produces a dependency.
    assign rd_live   = ex_mem_read && (ex_rd != '0);
    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
    assign hazard    = rd_live && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencing for the 5-stage pipeline registers and PC
// Ports:
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   id_rs1/id_rs2/id_uses_rs1/2    ID-stage source operands
//   ex_rd, ex_mem_read             EX-stage destination and load flag
//   ex_multicycle                  EX holds a mul/div
//   ex_branch_taken                EX resolved a taken branch/jump
//   mem_access, mem_ready          MEM-stage data memory handshake
//   *_load_enable                  per-register load enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   *_flush                        per-register bubble insertion (IF/ID, ID/EX, EX/MEM)
//   busy                           multi-cycle op occupying EX
//   stall_cycles                   count of cycles with the PC held
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_WIDTH      = 3,
    parameter int PERF_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    input  logic                      ex_multicycle,
    input  logic                      ex_branch_taken,
    input  logic                      mem_access,
    input  logic                      mem_ready,
    output logic                      pc_load_enable,
    output logic                      if_id_load_enable,
    output logic                      id_ex_load_enable,
    output logic                      ex_mem_load_enable,
    output logic                      mem_wb_load_enable,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic                      ex_mem_flush,
    output logic                      busy,
    output logic [PERF_WIDTH-1:0]     stall_cycles
);

    // Entering EX_BUSY already costs one stall cycle, and the release cycle is not a stall,
    // so the counter starts two below the latency.
    localparam logic [CNT_WIDTH-1:0] BUSY_INIT = CNT_WIDTH'(MULDIV_LATENCY - 2);

    state_t                     state;
    state_t                     state_next;
    logic [CNT_WIDTH-1:0]       cnt;
    logic [CNT_WIDTH-1:0]       cnt_next;
    logic [NUM_REGS-1:0]        en;
    logic [REG_EX_MEM:REG_IF_ID] flush;
    logic                       load_use;
    logic                       mem_wait;

    load_use_detect #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (load_use)
    );

    assign mem_wait = mem_access && !mem_ready;

    always_comb begin
        en         = '1;
        flush      = '0;
        state_next = state;
        cnt_next   = cnt;

        if (rst) begin
            en         = '0;
            state_next = RUN;
            cnt_next   = '0;
        end else if (mem_wait) begin
            // Whole pipe freezes; state and cnt hold so an EX_BUSY stall resumes where it left off.
            en = '0;
        end else if (state == EX_BUSY) begin
            if (cnt != '0) begin
                en[REG_PC]        = 1'b0;
                en[REG_IF_ID]     = 1'b0;
                en[REG_ID_EX]     = 1'b0;
                en[REG_EX_MEM]    = 1'b0;
                flush[REG_EX_MEM] = 1'b1;
                cnt_next          = cnt - CNT_WIDTH'(1);
            end else begin
                state_next = RUN;
            end
        end else if (ex_multicycle) begin
            // Upstream holds; a bubble drains into MEM while the op stays in EX.
            en[REG_PC]        = 1'b0;
            en[REG_IF_ID]     = 1'b0;
            en[REG_ID_EX]     = 1'b0;
            en[REG_EX_MEM]    = 1'b0;
            flush[REG_EX_MEM] = 1'b1;
            state_next        = EX_BUSY;
            cnt_next          = BUSY_INIT;
        end else if (ex_branch_taken) begin
            // Enables stay high; the flush wins at the register and kills both wrong-path slots.
            flush[REG_IF_ID] = 1'b1;
            flush[REG_ID_EX] = 1'b1;
        end else if (load_use) begin
            en[REG_PC]       = 1'b0;
            en[REG_IF_ID]    = 1'b0;
            en[REG_ID_EX]    = 1'b0;
            flush[REG_ID_EX] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (!en[REG_PC]) begin
                stall_cycles <= stall_cycles + PERF_WIDTH'(1);
            end
        end
    end

    assign pc_load_enable     = en[REG_PC];
    assign if_id_load_enable  = en[REG_IF_ID];
    assign id_ex_load_enable  = en[REG_ID_EX];
    assign ex_mem_load_enable = en[REG_EX_MEM];
    assign mem_wb_load_enable = en[REG_MEM_WB];
    assign if_id_flush        = flush[REG_IF_ID];
    assign id_ex_flush        = flush[REG_ID_EX];
    assign ex_mem_flush       = flush[REG_EX_MEM];
    assign busy               = (state == EX_BUSY);

endmodule
